// File: rtl/stripe_sequencer.sv
// Drives PE_array_64 through a banded alignment: loads each B stripe, streams A from a running base, collects per-stripe max.
// Four cycles from LOAD_B to the first valid A; one A base per cycle; o_score_valid one cycle after i_stripe_end.
module stripe_sequencer #(
    parameter int SEQ_LEN     = 1024,
    parameter int PE_NUM      = 64,
    parameter int NUM_STRIPES = 16,
    parameter int ADDR_W      = 10,
    parameter int SCORE_W     = 14,
    parameter int TIMEOUT     = 128,
    parameter int SIDX_W      = (NUM_STRIPES > 1) ? $clog2(NUM_STRIPES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_go,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_a_ren,
    output logic [ADDR_W-1:0]     o_a_addr,
    input  logic [1:0]            i_a_data,
    output logic                  o_b_ren,
    output logic [SIDX_W-1:0]     o_b_addr,
    input  logic [2*PE_NUM-1:0]   i_b_data,
    output logic                  o_pe_start,
    output logic [1:0]            o_pe_A,
    output logic [2*PE_NUM-1:0]   o_pe_B,
    input  logic                  i_stripe_end,
    input  logic [ADDR_W-1:0]     i_start_position,
    input  logic [SCORE_W-1:0]    i_max_score_stripe,
    output logic                  o_score_valid,
    output logic [SIDX_W-1:0]     o_stripe_idx,
    output logic [SCORE_W-1:0]    o_stripe_score,
    output logic [SCORE_W-1:0]    o_best_score,
    output logic [SIDX_W-1:0]     o_best_stripe,
    output logic                  o_timeout
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_B,
        S_LATCH_B,
        S_GAP,
        S_STREAM,
        S_DRAIN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [SIDX_W-1:0]    sidx_q, sidx_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 rd_on_q, rd_on_d;
    logic                 a_vld_q, a_vld_d;
    logic                 a_last_q, a_last_d;
    logic [TO_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0]    cap_pos_q, cap_pos_d;
    logic [SCORE_W-1:0]   res_score_q, res_score_d;
    logic [SIDX_W-1:0]    res_idx_q, res_idx_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [SIDX_W-1:0]    best_stripe_q, best_stripe_d;
    logic                 timeout_q, timeout_d;
    logic [2*PE_NUM-1:0]  pe_b_q, pe_b_d;

    logic                 a_ren;
    logic                 capture;
    logic                 last_stripe;
    logic [ADDR_W:0]      next_base;

    // Reads stop in the same cycle the array flags stripe end.
    assign a_ren       = (state_q == S_STREAM) && rd_on_q && !i_stripe_end;
    assign last_stripe = (sidx_q == SIDX_W'(NUM_STRIPES - 1));
    assign next_base   = {1'b0, base_q} + {1'b0, cap_pos_q} + (ADDR_W + 1)'(1);

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        sidx_d        = sidx_q;
        rd_addr_d     = rd_addr_q;
        rd_on_d       = rd_on_q;
        a_vld_d       = 1'b0;
        a_last_d      = 1'b0;
        drain_cnt_d   = drain_cnt_q;
        cap_pos_d     = cap_pos_q;
        res_score_d   = res_score_q;
        res_idx_d     = res_idx_q;
        best_score_d  = best_score_q;
        best_stripe_d = best_stripe_q;
        timeout_d     = timeout_q;
        pe_b_d        = pe_b_q;
        capture       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    best_score_d  = '0;
                    best_stripe_d = '0;
                    timeout_d     = 1'b0;
                    sidx_d        = '0;
                    base_d        = '0;
                    state_d       = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                state_d = S_LATCH_B;
            end
            S_LATCH_B: begin
                pe_b_d  = i_b_data;
                state_d = S_GAP;
            end
            S_GAP: begin
                rd_addr_d   = base_q;
                rd_on_d     = 1'b1;
                drain_cnt_d = '0;
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                if (i_stripe_end) begin
                    capture = 1'b1;
                    rd_on_d = 1'b0;
                    state_d = S_REPORT;
                end else begin
                    if (a_ren) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        a_vld_d   = 1'b1;
                        a_last_d  = (rd_addr_q == ADDR_W'(SEQ_LEN - 1));
                        if (rd_addr_q == ADDR_W'(SEQ_LEN - 1)) begin
                            rd_on_d = 1'b0;
                        end
                    end
                    if (a_vld_q && a_last_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (i_stripe_end) begin
                    capture = 1'b1;
                    state_d = S_REPORT;
                end else if (drain_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Report whatever the array holds so the host still sees a score.
                    capture   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_REPORT;
                end else begin
                    drain_cnt_d = drain_cnt_q + TO_W'(1);
                end
            end
            S_REPORT: begin
                if (res_score_q > best_score_q) begin
                    best_score_d  = res_score_q;
                    best_stripe_d = res_idx_q;
                end
                if (last_stripe || (next_base >= (ADDR_W + 1)'(SEQ_LEN)) || timeout_q) begin
                    state_d = S_DONE;
                end else begin
                    base_d  = next_base[ADDR_W-1:0];
                    sidx_d  = sidx_q + SIDX_W'(1);
                    state_d = S_LOAD_B;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            cap_pos_d   = i_start_position;
            res_score_d = i_max_score_stripe;
            res_idx_d   = sidx_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            sidx_q        <= '0;
            rd_addr_q     <= '0;
            rd_on_q       <= 1'b0;
            a_vld_q       <= 1'b0;
            a_last_q      <= 1'b0;
            drain_cnt_q   <= '0;
            cap_pos_q     <= '0;
            res_score_q   <= '0;
            res_idx_q     <= '0;
            best_score_q  <= '0;
            best_stripe_q <= '0;
            timeout_q     <= 1'b0;
            pe_b_q        <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            sidx_q        <= sidx_d;
            rd_addr_q     <= rd_addr_d;
            rd_on_q       <= rd_on_d;
            a_vld_q       <= a_vld_d;
            a_last_q      <= a_last_d;
            drain_cnt_q   <= drain_cnt_d;
            cap_pos_q     <= cap_pos_d;
            res_score_q   <= res_score_d;
            res_idx_q     <= res_idx_d;
            best_score_q  <= best_score_d;
            best_stripe_q <= best_stripe_d;
            timeout_q     <= timeout_d;
            pe_b_q        <= pe_b_d;
        end
    end

    // A data comes straight off the RAM output register, so base and start line up in one cycle.
    assign o_busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done         = (state_q == S_DONE);
    assign o_a_ren        = a_ren;
    assign o_a_addr       = rd_addr_q;
    assign o_b_ren        = (state_q == S_LOAD_B);
    assign o_b_addr       = sidx_q;
    assign o_pe_start     = (state_q == S_STREAM) && a_vld_q && !i_stripe_end;
    assign o_pe_A         = a_vld_q ? i_a_data : 2'b00;
    assign o_pe_B         = pe_b_q;
    assign o_score_valid  = (state_q == S_REPORT);
    assign o_stripe_idx   = res_idx_q;
    assign o_stripe_score = res_score_q;
    assign o_best_score   = best_score_q;
    assign o_best_stripe  = best_stripe_q;
    assign o_timeout      = timeout_q;

endmodule

// File: doc/stripe_sequencer.md
# stripe_sequencer

Hardware driver for `PE_array_64` that runs a complete banded alignment without a testbench.
- Fetches each 64-base stripe of sequence B from B memory and presents it on the array's packed B port.
- Streams sequence A one base per cycle from A memory, starting at a running start position.
- Detects stripe end, captures the stripe's max score and advances the start position for the next stripe.
- Sits between the two sequence RAMs and the PE array; the top-level host controls it with a go/done handshake.

## Interface
- `SEQ_LEN`, 1024, length of sequence A in bases
- `PE_NUM`, 64, PEs per stripe (bases of B per stripe)
- `NUM_STRIPES`, 16, stripes of B per run
- `ADDR_W`, 10, A address / start-position width
- `SCORE_W`, 14, score width
- `TIMEOUT`, 128, max cycles to wait for stripe end after A is exhausted

Ports:
- `i_clk` in 1: clock
- `i_rst` in 1: synchronous, active-high reset
- `i_go` in 1: start-run pulse; ignored while `o_busy`
- `o_busy` out 1: run in progress
- `o_done` out 1: one-cycle pulse at run end
- `o_a_ren` out 1: A read enable
- `o_a_addr` out ADDR_W: A read address
- `i_a_data` in 2: A base; valid 1 cycle after `o_a_ren`
- `o_b_ren` out 1: B read enable
- `o_b_addr` out clog2(NUM_STRIPES): B stripe index
- `i_b_data` in 2*PE_NUM: packed stripe; valid 1 cycle after `o_b_ren`; base n sits in bits [2n+1:2n]
- `o_pe_start` out 1: drives PE `i_start`
- `o_pe_A` out 2: drives PE `i_A`
- `o_pe_B` out 2*PE_NUM: drives PE `i_B`
- `i_stripe_end` in 1: from PE `o_stripe_end`
- `i_start_position` in ADDR_W: from PE `o_start_position`; relative to the stripe's first A index
- `i_max_score_stripe` in SCORE_W: from PE `o_max_score_stripe`
- `o_score_valid` out 1: one-cycle pulse per finished stripe
- `o_stripe_idx` out clog2(NUM_STRIPES): index of the finished stripe
- `o_stripe_score` out SCORE_W: that stripe's max score
- `o_best_score` out SCORE_W: running max over stripes in this run
- `o_best_stripe` out clog2(NUM_STRIPES): stripe holding `o_best_score`
- `o_timeout` out 1: sticky; a stripe ended by timeout this run

## Operation
States: IDLE, LOAD_B, LATCH_B, GAP, STREAM, DRAIN, REPORT, DONE.
- IDLE: wait for `i_go`. On `i_go`, clear the best-score, timeout, stripe counter and base registers, then go to LOAD_B.
- LOAD_B: assert `o_b_ren` with `o_b_addr` = stripe index, then go to LATCH_B.
- LATCH_B: register `i_b_data` into `o_pe_B`, which holds until the next LATCH_B. Go to GAP.
- GAP: one cycle with `o_pe_start`=0 so the array re-initialises, then go to STREAM.
- STREAM:
  - Issue `o_a_ren` at addresses base, base+1, … SEQ_LEN-1.
  - Each returned base is registered to `o_pe_A`; `o_pe_start`=1 in the same cycle.
  - On `i_stripe_end`=1: stop issuing reads, discard any in-flight read, go to REPORT.
  - After address SEQ_LEN-1 has been delivered without a stripe end: go to DRAIN.
- DRAIN: `o_pe_start`=0. Wait for `i_stripe_end` → REPORT. After TIMEOUT cycles → set `o_timeout`, go to REPORT.
- REPORT:
  - Pulse `o_score_valid` with the captured stripe index and score.
  - If score > `o_best_score` (strictly; ties keep the earlier stripe), update the best score and stripe.
  - Update base: next = base + `i_start_position` + 1, computed at ADDR_W+1 bits.
  - If the stripe was the last one, or next ≥ SEQ_LEN, or the stripe ended by timeout: go to DONE.
  - Otherwise increment the stripe index and go to LOAD_B.
- DONE: pulse `o_done`, clear `o_busy`, go to IDLE.

Capture and gating rules:
- `i_start_position` and `i_max_score_stripe` are captured in the cycle `i_stripe_end`=1.
- `o_pe_start` is gated combinationally: it is 0 in any cycle where `i_stripe_end`=1.

## Timing
- Reset: state IDLE; every output is 0, including `o_pe_B`, `o_best_score` and `o_timeout`.
- Reset mid-run aborts immediately, with no `o_done`.
- `o_busy` rises the cycle after `i_go` and falls in the cycle `o_done` pulses.
- Stripe overhead before the first valid A: LOAD_B, LATCH_B, GAP, first read = 4 cycles. First `o_pe_start`=1 is 4 cycles after entering LOAD_B.
- A stream throughput is 1 base per cycle with no bubbles.
- `o_score_valid` fires 1 cycle after `i_stripe_end`. The next LOAD_B follows in the next cycle.
- Results on `o_stripe_idx` and `o_stripe_score` hold until the next REPORT.
- `o_best_score` and `o_best_stripe` update in the cycle after REPORT and hold after DONE until the next `i_go`.
- `i_stripe_end` in IDLE, LOAD_B, LATCH_B or GAP is ignored.
- `i_go` coincident with `o_done` is ignored.

## Test plan
- Single stripe (NUM_STRIPES=1):
  - Stimulus: PE model raises stripe_end after 100 A bases with start_position=37 and score 250.
  - Expect: A addresses 0..99, one `o_score_valid` with score 250, `o_best_score`=250, `o_done` 1 cycle later.
- Multi-stripe chaining:
  - Stimulus: start_positions 37, 20, 5.
  - Expect: stripe 1 starts at A address 38, stripe 2 at 59, stripe 3 at 65; B addresses 0, 1, 2 and `o_pe_B` matches memory.
- Best score:
  - Stimulus: stripe scores 100, 300, 300, 50.
  - Expect: `o_best_score`=300, `o_best_stripe`=1 (tie keeps the earlier stripe).
- A exhaustion:
  - Stimulus: base reaches 1000; stripe_end arrives 10 cycles after the last base, start_position=30.
  - Expect: DRAIN holds `o_pe_start`=0; next=1031 ≥ 1024, so `o_done` pulses with no further LOAD_B.
- Timeout: stripe_end never arrives → `o_timeout`=1 after 128 DRAIN cycles, REPORT, then `o_done`.
- Reset and go hygiene:
  - Stimulus: assert `i_rst` mid-STREAM; also pulse `i_go` while busy.
  - Expect: all outputs 0 next cycle and no `o_done`; `i_go` during busy has no effect.
